// File: rtl/irq_pending_encoder_pkg.sv
// Shared sizing, FSM state type and one-hot helper for the pending-request encoder.
package irq_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/irq_pending_encoder_if.sv
// Request capture inputs plus the index valid/ready channel of the pending encoder.
interface irq_pending_encoder_if;
  import irq_pkg::*;

  logic [N_REQ-1:0] req_in;
  logic [N_REQ-1:0] mask;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [N_REQ-1:0] pending;
  logic             overrun;

  modport master (
    input  req_in, mask, out_ready,
    output out_valid, out_idx, pending, overrun
  );

  modport slave (
    output req_in, mask, out_ready,
    input  out_valid, out_idx, pending, overrun
  );

endinterface

// File: rtl/irq_pending_encoder_prio_enc_n.sv
// Combinational highest-set-bit encoder; zero latency, no flow control.
// An all-zero input yields idx=0 with any=0.
module prio_enc_n #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] in_vec,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (in_vec[i]) idx = W'(i);
    end
  end

  assign any = |in_vec;

endmodule

// File: rtl/irq_pending_encoder.sv
// Sticky 8-line request capture with masked priority select (bit 7 highest) onto valid/ready.
// Edge to out_valid in 2 cycles; presented index held until accepted, back-to-back on accept.
module irq_pending_encoder
  import irq_pkg::*;
#(
  parameter bit EDGE = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  irq_pending_encoder_if.master bus
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt, enc_idx;
  logic [N_REQ-1:0] pending_q, pending_nxt;
  logic [N_REQ-1:0] req_d, ev, clr, eligible, rem, enc_in;
  logic             overrun_q, overrun_nxt, enc_any, accept;

  assign ev       = EDGE ? (bus.req_in & ~req_d) : bus.req_in;
  assign accept   = (state == PRESENT) && bus.out_ready;
  assign clr      = accept ? onehot(idx_q) : '0;
  assign eligible = pending_q & ~bus.mask;
  assign rem      = eligible & ~clr;
  assign enc_in   = (state == PRESENT) ? rem : eligible;

  // A fresh event on the bit being cleared re-arms it rather than counting as overrun.
  assign pending_nxt = (pending_q & ~clr) | ev;
  assign overrun_nxt = |(ev & pending_q & ~clr);

  prio_enc_n #(
    .N (N_REQ),
    .W (IDX_W)
  ) u_prio (
    .in_vec (enc_in),
    .idx    (enc_idx),
    .any    (enc_any)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    case (state)
      IDLE: begin
        if (enc_any) begin
          idx_nxt   = enc_idx;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        // No re-selection while stalled: only an accept may move the index.
        if (bus.out_ready) begin
          if (enc_any) idx_nxt = enc_idx;
          else         state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx_q     <= '0;
      pending_q <= '0;
      overrun_q <= 1'b0;
      req_d     <= '0;
    end else begin
      state     <= state_nxt;
      idx_q     <= idx_nxt;
      pending_q <= pending_nxt;
      overrun_q <= overrun_nxt;
      req_d     <= bus.req_in;
    end
  end

  assign bus.out_valid = (state == PRESENT);
  assign bus.out_idx   = idx_q;
  assign bus.pending   = pending_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_irq_pending_encoder.sv
// Directed and randomized checks of irq_pending_encoder (EDGE=1 and EDGE=0 instances)
// against a spec-level behavioural model.
module tb_irq_pending_encoder;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  irq_pending_encoder_if ia ();
  irq_pending_encoder_if ib ();

  irq_pending_encoder #(.EDGE(1'b1)) dut_a (.clk(clk), .rst(rst_a), .bus(ia));
  irq_pending_encoder #(.EDGE(1'b0)) dut_b (.clk(clk), .rst(rst_b), .bus(ib));

  typedef struct {
    logic [7:0] pend;
    logic       vld;
    int         idx;
    logic       ovr;
    logic [7:0] reqd;
  } mdl_t;

  mdl_t ma, mb;

  function automatic int top_bit(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  // One clock of the specified behaviour, in terms of sets of request lines.
  function automatic mdl_t model(input bit edge_mode, input logic r, input logic [7:0] req,
                                 input logic [7:0] msk, input logic rdy, input mdl_t c);
    mdl_t       n;
    logic [7:0] ev, taken, avail;
    if (r) begin
      n.pend = 8'h00; n.vld = 1'b0; n.idx = 0; n.ovr = 1'b0; n.reqd = 8'h00;
      return n;
    end
    n     = c;
    ev    = edge_mode ? (req & ~c.reqd) : req;
    taken = (c.vld && rdy) ? 8'(1 << c.idx) : 8'h00;
    avail = c.pend & ~msk & ~taken;
    if (!c.vld || rdy) begin
      n.vld = (avail != 0);
      if (avail != 0) n.idx = top_bit(avail);
    end
    n.ovr  = ((ev & c.pend & ~taken) != 0);
    n.pend = (c.pend & ~taken) | ev;
    n.reqd = req;
    return n;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    ma = model(1'b1, rst_a, ia.req_in, ia.mask, ia.out_ready, ma);
    mb = model(1'b0, rst_b, ib.req_in, ib.mask, ib.out_ready, mb);
    #1;
    cmp("a.valid",   32'(ia.out_valid), 32'(ma.vld));
    cmp("a.pending", 32'(ia.pending),   32'(ma.pend));
    cmp("a.overrun", 32'(ia.overrun),   32'(ma.ovr));
    if (ma.vld) cmp("a.idx", 32'(ia.out_idx), 32'(ma.idx));
    cmp("b.valid",   32'(ib.out_valid), 32'(mb.vld));
    cmp("b.pending", 32'(ib.pending),   32'(mb.pend));
    if (mb.vld) cmp("b.idx", 32'(ib.out_idx), 32'(mb.idx));
  endtask

  initial begin
    int n;
    rst_a = 1'b1; rst_b = 1'b1;
    ia.req_in = 8'hFF; ia.mask = 8'h00; ia.out_ready = 1'b0;
    ib.req_in = 8'h00; ib.mask = 8'h00; ib.out_ready = 1'b0;
    ma = model(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, ma);
    mb = ma;

    // 1: reset with all lines high, then release
    step(); step();
    cmp("t1.rst_pending", 32'(ia.pending), 32'h00);
    cmp("t1.rst_valid",   32'(ia.out_valid), 32'h0);
    cmp("t1.rst_idx",     32'(ia.out_idx), 32'h0);
    cmp("t1.rst_overrun", 32'(ia.overrun), 32'h0);
    rst_a = 1'b0;
    step();
    cmp("t1.valid_early", 32'(ia.out_valid), 32'h0);
    step();
    cmp("t1.valid", 32'(ia.out_valid), 32'h1);
    cmp("t1.idx7",  32'(ia.out_idx), 32'h7);
    ia.req_in = 8'h00; ia.out_ready = 1'b1;
    n = 0;
    while (ia.out_valid && n < 20) begin step(); n++; end
    cmp("t1.drain_timeout", 32'(ia.out_valid), 32'h0);
    cmp("t1.drained", 32'(ia.pending), 32'h00);

    // 2: priority drain of 8'h29
    ia.req_in = 8'h29; step(); ia.req_in = 8'h00;
    step();
    cmp("t2.idx5", 32'(ia.out_idx), 32'h5);
    step();
    cmp("t2.idx3", 32'(ia.out_idx), 32'h3);
    step();
    cmp("t2.idx0", 32'(ia.out_idx), 32'h0);
    step();
    cmp("t2.idle",  32'(ia.out_valid), 32'h0);
    cmp("t2.empty", 32'(ia.pending), 32'h00);

    // 3: stall keeps index stable despite higher-priority arrival
    ia.out_ready = 1'b0;
    ia.req_in = 8'h04; step(); ia.req_in = 8'h00; step(); step();
    ia.req_in = 8'h40; step(); ia.req_in = 8'h00; step(); step();
    cmp("t3.stall_idx", 32'(ia.out_idx), 32'h2);
    cmp("t3.stall_pend", 32'(ia.pending), 32'h44);
    ia.out_ready = 1'b1;
    step();
    cmp("t3.next_idx6", 32'(ia.out_idx), 32'h6);
    cmp("t3.next_vld",  32'(ia.out_valid), 32'h1);
    step();

    // 4: masked bit retained until mask drops
    ia.out_ready = 1'b0; ia.mask = 8'h80;
    ia.req_in = 8'h81; step(); ia.req_in = 8'h00; step(); step();
    cmp("t4.idx0", 32'(ia.out_idx), 32'h0);
    ia.out_ready = 1'b1;
    step();
    cmp("t4.idle", 32'(ia.out_valid), 32'h0);
    cmp("t4.held", 32'(ia.pending), 32'h80);
    step();
    cmp("t4.still_masked", 32'(ia.out_valid), 32'h0);
    ia.mask = 8'h00;
    step();
    cmp("t4.unmask_vld", 32'(ia.out_valid), 32'h1);
    cmp("t4.unmask_idx", 32'(ia.out_idx), 32'h7);
    step();

    // 5: overrun versus same-cycle re-request
    ia.out_ready = 1'b0;
    ia.req_in = 8'h10; step(); ia.req_in = 8'h00; step(); step();
    ia.req_in = 8'h10; step();
    cmp("t5.overrun", 32'(ia.overrun), 32'h1);
    ia.req_in = 8'h00; step();
    cmp("t5.ovr_pulse", 32'(ia.overrun), 32'h0);
    ia.req_in = 8'h10; ia.out_ready = 1'b1; step();
    cmp("t5.no_overrun", 32'(ia.overrun), 32'h0);
    cmp("t5.kept", 32'(ia.pending[4]), 32'h1);
    ia.req_in = 8'h00; step();
    cmp("t5.repres_vld", 32'(ia.out_valid), 32'h1);
    cmp("t5.repres_idx", 32'(ia.out_idx), 32'h4);
    step();

    // 6: reset mid-handshake, then level capture on the EDGE=0 instance
    ia.out_ready = 1'b0;
    ia.req_in = 8'h0C; step(); ia.req_in = 8'h00; step(); step();
    cmp("t6.pre_idx", 32'(ia.out_idx), 32'h3);
    cmp("t6.pre_pend", 32'(ia.pending), 32'h0C);
    rst_a = 1'b1; step(); rst_a = 1'b0;
    cmp("t6.rst_valid", 32'(ia.out_valid), 32'h0);
    cmp("t6.rst_pend",  32'(ia.pending), 32'h00);
    cmp("t6.rst_idx",   32'(ia.out_idx), 32'h0);
    ib.req_in = 8'h01; ib.out_ready = 1'b1; rst_b = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ib.out_valid && ib.out_idx == 3'd0) n++;
    end
    cmp("t6.level_repres", 32'(n >= 4), 32'h1);

    // Randomized traffic on both instances
    for (int i = 0; i < 600; i++) begin
      ia.req_in    = 8'($urandom) & 8'($urandom);
      ia.mask      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      ia.out_ready = ($urandom_range(0, 2) != 0);
      rst_a        = ($urandom_range(0, 60) == 0);
      ib.req_in    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      ib.mask      = 8'($urandom) & 8'($urandom);
      ib.out_ready = ($urandom_range(0, 1) != 0);
      rst_b        = ($urandom_range(0, 80) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
